// File: rtl/jtag_host_port.sv
// JTAG host port: walks the TAP from Run-Test/Idle through one IR or DR shift and back, capturing TDO.
// Optional macro JTAG_HOST_TLR_EN adds a post-reset Test-Logic-Reset/Idle init sequence.
`timescale 1ns/1ps
module jtag_host_port #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_isIr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_TCK,
  output logic              o_TMS,
  output logic              o_TDI,
  input  logic              i_TDO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  typedef enum logic [2:0] {INIT, IDLE, HDR, SHIFT, TRL, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  divCnt;
  logic [CNT_W-1:0]  idx;
  logic              isIrReg;
  logic [LEN_W-1:0]  lenReg;
  logic [DATA_W-1:0] txReg;
  logic [DATA_W-1:0] dataOutReg;
  logic              busyReg, doneReg, tckReg, tmsReg, tdiReg;

  logic [LEN_W-1:0]  lenEff;
  logic [CNT_W-1:0]  nextIdx, lastShift, lastHdr;
  logic              phaseEnd;

  always_comb begin
    lenEff    = (int'(i_len) > DATA_W) ? LEN_W'(DATA_W) : i_len;
    nextIdx   = idx + CNT_W'(1);
    lastShift = CNT_W'(lenReg) - CNT_W'(1);
    lastHdr   = isIrReg ? CNT_W'(3) : CNT_W'(2);
    phaseEnd  = (divCnt == DIV_W'(CLK_DIV - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
`ifdef JTAG_HOST_TLR_EN
      state   <= INIT;
      busyReg <= 1'b1;
`else
      state   <= IDLE;
      busyReg <= 1'b0;
`endif
      divCnt     <= '0;
      idx        <= '0;
      isIrReg    <= 1'b0;
      lenReg     <= '0;
      txReg      <= '0;
      dataOutReg <= '0;
      doneReg    <= 1'b0;
      tckReg     <= 1'b0;
      tmsReg     <= 1'b1;
      tdiReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          tckReg <= 1'b0;
          tmsReg <= 1'b0;
          tdiReg <= 1'b0;
          if (i_start) begin
            isIrReg    <= i_isIr;
            lenReg     <= lenEff;
            txReg      <= i_data;
            dataOutReg <= '0;
            divCnt     <= '0;
            idx        <= '0;
            if (lenEff == '0) begin
              state   <= DONE;
              doneReg <= 1'b1;
            end else begin
              state   <= HDR;
              busyReg <= 1'b1;
              tmsReg  <= 1'b1;
            end
          end
        end
        default: begin
          if (!phaseEnd) begin
            divCnt <= divCnt + DIV_W'(1);
          end else begin
            divCnt <= '0;
            if (!tckReg) begin
              // Rising TCK edge: target samples TMS/TDI, we sample TDO.
              tckReg <= 1'b1;
              if (state == SHIFT) begin
                for (int k = 0; k < DATA_W; k++) begin
                  if (idx == CNT_W'(k)) dataOutReg[k] <= i_TDO;
                end
              end
            end else begin
              // Falling TCK edge: set up TMS/TDI for the next period.
              tckReg <= 1'b0;
              case (state)
                INIT: begin
                  if (idx == CNT_W'(5)) begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                  end else begin
                    idx    <= nextIdx;
                    tmsReg <= (nextIdx < CNT_W'(5));
                  end
                end
                HDR: begin
                  if (idx == lastHdr) begin
                    state  <= SHIFT;
                    idx    <= '0;
                    tmsReg <= (lenReg == LEN_W'(1));
                    tdiReg <= txReg[0];
                    txReg  <= txReg >> 1;
                  end else begin
                    idx    <= nextIdx;
                    tmsReg <= isIrReg && (idx == '0);
                  end
                end
                SHIFT: begin
                  if (idx == lastShift) begin
                    state  <= TRL;
                    idx    <= '0;
                    tmsReg <= 1'b1;
                    tdiReg <= 1'b0;
                  end else begin
                    idx    <= nextIdx;
                    tmsReg <= (nextIdx == lastShift);
                    tdiReg <= txReg[0];
                    txReg  <= txReg >> 1;
                  end
                end
                TRL: begin
                  tmsReg <= 1'b0;
                  if (idx == CNT_W'(1)) begin
                    state   <= DONE;
                    doneReg <= 1'b1;
                    busyReg <= 1'b0;
                  end else begin
                    idx <= nextIdx;
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign o_busy = busyReg;
  assign o_done = doneReg;
  assign o_data = dataOutReg;
  assign o_TCK  = tckReg;
  assign o_TMS  = tmsReg;
  assign o_TDI  = tdiReg;

endmodule

// File: tb/tb_jtag_host_port.sv
// Scoreboard bench for jtag_host_port: expected TMS/TDI/TDO traces pushed at start, compared at o_done.
`timescale 1ns/1ps
module tb_jtag_host_port;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = $clog2(DATA_W + 1);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, isIr = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] data = '0;
  logic busy, done, tck, tms, tdi, tdo;
  logic [DATA_W-1:0] dataOut;

  int   tdoMode = 0;  // 0: tied 0, 1: tied 1, 2: echo TDI one bit later
  logic tdoEcho = 1'b0;

  jtag_host_port #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_isIr(isIr), .i_len(len), .i_data(data),
    .o_busy(busy), .o_done(done), .o_data(dataOut),
    .o_TCK(tck), .o_TMS(tms), .o_TDI(tdi), .i_TDO(tdo)
  );

  always #5 clk = ~clk;

  assign tdo = (tdoMode == 2) ? tdoEcho : (tdoMode == 1);
  always @(posedge tck) tdoEcho <= tdi;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic tmsLog [0:4095];
  logic tdiLog [0:4095];
  int   tckTotal = 0;
  always @(posedge tck) begin
    tmsLog[tckTotal] <= tms;
    tdiLog[tckTotal] <= tdi;
    tckTotal <= tckTotal + 1;
  end

  int doneCnt = 0;
  always @(negedge clk) if (done) doneCnt <= doneCnt + 1;

  typedef struct {
    logic [31:0] tmsSeq;
    logic [31:0] tdiSeq;
    logic [31:0] dataExp;
    int nTck;
    int lat;
    int startCycle;
    int tckBase;
  } exp_t;
  exp_t sb[$];

  int passCnt = 0;
  int checkCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic driveStart(input logic ir, input int l, input logic [DATA_W-1:0] d);
    isIr  = ir;
    len   = LEN_W'(l);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic startTxn(input logic ir, input int l, input logic [DATA_W-1:0] d, input int mode);
    exp_t e;
    int lenE, hdr;
    logic [31:0] mask;
    tdoMode = mode;
    lenE = (l > DATA_W) ? DATA_W : l;
    hdr  = ir ? 4 : 3;
    mask = (32'h1 << lenE) - 32'h1;
    e.tmsSeq = '0;
    e.tdiSeq = '0;
    e.nTck = (lenE == 0) ? 0 : hdr + lenE + 2;
    if (lenE > 0) begin
      e.tmsSeq[0] = 1'b1;
      if (ir) e.tmsSeq[1] = 1'b1;
      e.tmsSeq[hdr + lenE - 1] = 1'b1;
      e.tmsSeq[hdr + lenE]     = 1'b1;
      for (int k = 0; k < lenE; k++) e.tdiSeq[hdr + k] = d[k];
    end
    case (mode)
      1:       e.dataExp = mask;
      2:       e.dataExp = ({16'h0, d} << 1) & mask;
      default: e.dataExp = '0;
    endcase
    e.lat        = 1 + 2 * CLK_DIV * e.nTck;
    e.startCycle = cycle;
    e.tckBase    = tckTotal;
    sb.push_back(e);
    $display("txn start: ir=%0d len=%0d data=0x%04h tdoMode=%0d expect tck=%0d data=0x%0h",
             ir, l, d, mode, e.nTck, e.dataExp);
    driveStart(ir, l, d);
  endtask

  task automatic waitDone(input string tag);
    exp_t e;
    logic [31:0] obsTms, obsTdi;
    int n, lim;
    lim = 0;
    while (!done && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    if (sb.size() == 0) begin
      checkVal({tag, " scoreboard"}, 32'(0), 32'(1));
      return;
    end
    e = sb.pop_front();
    if (!done) begin
      checkVal({tag, " done timeout"}, 32'(done), 32'(1));
      return;
    end
    n = tckTotal - e.tckBase;
    obsTms = '0;
    obsTdi = '0;
    for (int i = 0; i < n && i < 32; i++) begin
      obsTms[i] = tmsLog[e.tckBase + i];
      obsTdi[i] = tdiLog[e.tckBase + i];
    end
    checkVal({tag, " tckCount"}, 32'(n), 32'(e.nTck));
    checkVal({tag, " tms"}, obsTms, e.tmsSeq);
    checkVal({tag, " tdi"}, obsTdi, e.tdiSeq);
    checkVal({tag, " data"}, 32'(dataOut), e.dataExp);
    checkVal({tag, " latency"}, 32'(cycle - e.startCycle), 32'(e.lat));
    checkVal({tag, " tckLowAtDone"}, 32'(tck), 32'(0));
    checkVal({tag, " busyAtDone"}, 32'(busy), 32'(0));
    $display("txn done: %s tck=%0d data=0x%04h latency=%0d", tag, n, dataOut, cycle - e.startCycle);
  endtask

  task automatic waitIdle(input string tag);
    int lim;
    lim = 0;
    while (busy && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    checkVal({tag, " idle"}, 32'(busy), 32'(0));
  endtask

  logic rstBusy;
  int base, d0, lim, busyLow;

  initial begin
`ifdef JTAG_HOST_TLR_EN
    rstBusy = 1'b1;
`else
    rstBusy = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkVal("rst tck", 32'(tck), 32'(0));
    checkVal("rst tms", 32'(tms), 32'(1));
    checkVal("rst tdi", 32'(tdi), 32'(0));
    checkVal("rst done", 32'(done), 32'(0));
    checkVal("rst data", 32'(dataOut), 32'(0));
    checkVal("rst busy", 32'(busy), 32'(rstBusy));
    base = tckTotal;
    d0 = doneCnt;
    rst = 1'b0;
`ifdef JTAG_HOST_TLR_EN
    busyLow = 0;
    lim = 0;
    while ((tckTotal - base) < 6 && lim < 500) begin
      @(negedge clk);
      if (!busy) busyLow++;
      if (lim == 3) driveStart(1'b0, 4, 16'h000F);
      lim++;
    end
    checkVal("init busyLow", 32'(busyLow), 32'(0));
    waitIdle("init");
    begin
      logic [31:0] obs;
      obs = '0;
      for (int i = 0; i < 6; i++) obs[i] = tmsLog[base + i];
      checkVal("init tms", obs, 32'h1F);
    end
    checkVal("init tckCount", 32'(tckTotal - base), 32'(6));
    checkVal("init noDone", 32'(doneCnt), 32'(d0));
`else
    repeat (2) @(negedge clk);
    checkVal("idle tms", 32'(tms), 32'(0));
`endif

    startTxn(1'b0, 16, 16'hA5C3, 2);
    waitDone("dr16echo");
    startTxn(1'b1, 4, 16'h0009, 1);
    waitDone("ir4tie1");
    startTxn(1'b0, 0, 16'hFFFF, 1);
    waitDone("len0");

    startTxn(1'b0, 20, 16'h3C5A, 2);
    repeat (30) @(negedge clk);
    checkVal("len20 busyMid", 32'(busy), 32'(1));
    driveStart(1'b1, 3, 16'h0007);
    checkVal("len20 busyAfterIgnored", 32'(busy), 32'(1));
    waitDone("len20");

    startTxn(1'b0, 1, 16'h0001, 0);
    waitDone("len1");
    startTxn(1'b1, 5, 16'h0015, 2);
    waitDone("b2b");

    for (int i = 0; i < 3; i++) begin
      startTxn(1'($urandom_range(0, 1)), int'($urandom_range(1, 16)),
               16'($urandom), int'($urandom_range(0, 2)));
      waitDone("rand");
    end

    // Abort in the middle of SHIFT.
    base = tckTotal;
    tdoMode = 1;
    driveStart(1'b0, 8, 16'h00FF);
    lim = 0;
    while ((tckTotal - base) < 5 && lim < 500) begin
      @(negedge clk);
      lim++;
    end
    checkVal("abort reachedShift", 32'(tckTotal - base >= 5), 32'(1));
    d0 = doneCnt;
    rst = 1'b1;
    #1;
    checkVal("abort tck", 32'(tck), 32'(0));
    checkVal("abort tms", 32'(tms), 32'(1));
    checkVal("abort busy", 32'(busy), 32'(rstBusy));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("abort noDone", 32'(doneCnt), 32'(d0));
    waitIdle("abort");

    startTxn(1'b0, 3, 16'h0005, 1);
    waitDone("recover");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passCnt, checkCnt);
    $fatal(1);
  end

endmodule
